alu_control_m: RTL and testbench

Parametrised successor to the single-cycle ALU decoder in the execute stage. Decodes `ctrl_alu_op`, `funct3` and `funct7` bits into the 4-bit ALU control code for base-ISA operations, distinguishing R-type from I-type. It also adds an iterative RV32M multiply/divide engine that stalls the pipeline while it runs. The block sits between the main decoder and the ALU/writeback mux in EX.

---
 rtl/alu_control_if.sv | 31 +++
 rtl/alu_control_m.sv | 136 +++++++++++++
 tb/tb_alu_control_m.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_if.sv
// EX-stage bundle between the main decoder and the ALU control / RV32M engine.
// Handshake: in_valid presents an instruction; while stall is high the producer holds every
// input steady; the instruction retires in the first cycle with in_valid high and stall low,
// which for an M-op is also the single cycle in which mdu_valid is high.
interface alu_control_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            kill;
    logic [1:0]      ctrl_alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            funct7_0;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      alu_ctrl;
    logic            is_mdu;
    logic            stall;
    logic            mdu_valid;
    logic [XLEN-1:0] mdu_result;

    modport master (
        output in_valid, kill, ctrl_alu_op, funct3, funct7_5, funct7_0, op_a, op_b,
        input  alu_ctrl, is_mdu, stall, mdu_valid, mdu_result
    );

    modport slave (
        input  in_valid, kill, ctrl_alu_op, funct3, funct7_5, funct7_0, op_a, op_b,
        output alu_ctrl, is_mdu, stall, mdu_valid, mdu_result
    );
endinterface

// File: rtl/alu_control_m.sv
// ALU control decoder plus an iterative RV32M multiply/divide engine that stalls EX.
// state_dbg exposes the FSM state: 0 IDLE, 1 MUL, 2 DIV, 3 DONE.
module alu_control_m #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_control_if.slave     bus,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(XLEN);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc, acc_step, mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   b_reg, a_mag, b_mag, half_sel, half_fix, result_final, mdu_result;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2:0]        f3_reg;
    logic              neg_reg, start_neg, sign_a, sign_b, a_neg, b_neg;
    logic              is_mdu, mdu_valid;
    logic [3:0]        alu_ctrl;

    assign is_mdu         = bus.in_valid & (bus.ctrl_alu_op == 2'b10) & bus.funct7_0;
    assign bus.is_mdu     = is_mdu;
    assign bus.stall      = is_mdu & (state != S_DONE);
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.mdu_valid  = mdu_valid;
    assign bus.mdu_result = mdu_result;
    assign state_dbg      = state;

    // I-type only honours bit 30 for shifts, so ADDI with imm[10]=1 stays ADD.
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (!is_mdu) begin
            case (bus.ctrl_alu_op)
                2'b00:   alu_ctrl = ALU_ADD;
                2'b01:   alu_ctrl = ALU_SUB;
                2'b10:   alu_ctrl = {bus.funct7_5, bus.funct3};
                default: alu_ctrl = (bus.funct3[1:0] == 2'b01) ? {bus.funct7_5, bus.funct3}
                                                                : {1'b0, bus.funct3};
            endcase
        end
    end

    always_comb begin
        sign_a = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) |
                 (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
        sign_b = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
        a_neg  = sign_a & bus.op_a[XLEN-1];
        b_neg  = sign_b & bus.op_b[XLEN-1];
        a_mag  = a_neg ? -bus.op_a : bus.op_a;
        b_mag  = b_neg ? -bus.op_b : bus.op_b;
        case (bus.funct3)
            3'b001:  start_neg = a_neg ^ b_neg;
            3'b010:  start_neg = a_neg;
            3'b100:  start_neg = (a_neg ^ b_neg) & (bus.op_b != '0);
            3'b110:  start_neg = a_neg;
            default: start_neg = 1'b0;
        endcase
    end

    // acc holds {high, low}: product-so-far / multiplier for MUL, remainder / dividend-quotient for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_reg} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_sh   = acc[2*XLEN-1:XLEN-1];
        div_diff = div_sh - {1'b0, b_reg};
        if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else                 div_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        acc_step = (state == S_DIV) ? div_next : mul_next;
        prod_fix = neg_reg ? -acc_step : acc_step;
        half_sel = f3_reg[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        half_fix = neg_reg ? -half_sel : half_sel;
        if (f3_reg[2])                 result_final = half_fix;
        else if (f3_reg[1:0] == 2'b00) result_final = prod_fix[XLEN-1:0];
        else                           result_final = prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_next = state;
        if (bus.kill) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (is_mdu) state_next = bus.funct3[2] ? S_DIV : S_MUL;
                S_MUL, S_DIV: if (count == '0) state_next = S_DONE;
                default:      state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            acc        <= '0;
            b_reg      <= '0;
            f3_reg     <= '0;
            neg_reg    <= 1'b0;
            mdu_valid  <= 1'b0;
            mdu_result <= '0;
        end else begin
            state     <= state_next;
            mdu_valid <= 1'b0;
            if (bus.kill) begin
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (is_mdu) begin
                            f3_reg  <= bus.funct3;
                            neg_reg <= start_neg;
                            acc     <= {{XLEN{1'b0}}, a_mag};
                            b_reg   <= b_mag;
                            count   <= CW'(XLEN - 1);
                        end
                    end
                    S_MUL, S_DIV: begin
                        acc <= acc_step;
                        if (count == '0) begin
                            mdu_valid  <= 1'b1;
                            mdu_result <= result_final;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_control_m.sv
// Bench for alu_control_m: directed decode and RV32M vectors against a behavioural model.
module tb_alu_control_m;
  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;
  int         v_cyc = 0;

  alu_control_if #(.XLEN(XLEN)) bus ();
  alu_control_m #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // behavioural model
  function automatic logic [3:0] dec_model(logic [1:0] op, logic [2:0] f3, logic f5);
    case (op)
      2'd0:    return 4'b0000;
      2'd1:    return 4'b1000;
      2'd2:    return {f5, f3};
      default: return (f3 == 3'd1 || f3 == 3'd5) ? {f5, f3} : {1'b0, f3};
    endcase
  endfunction

  function automatic logic [31:0] m_model(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ubs;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ubs = longint'(ub);
    r   = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ubs; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // scoreboard
  logic [XLEN-1:0] exp_q[$];
  bit mdl_busy  = 1'b0;
  int mdl_start = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_mdu, in_done;
      exp_mdu = bus.in_valid & (bus.ctrl_alu_op == 2'b10) & bus.funct7_0;
      in_done = mdl_busy && (cyc == mdl_start + XLEN + 1);
      chk("is_mdu", bus.is_mdu, exp_mdu);
      chk("alu_ctrl", bus.alu_ctrl,
          exp_mdu ? 4'b0000 : dec_model(bus.ctrl_alu_op, bus.funct3, bus.funct7_5));
      chk("stall", bus.stall, exp_mdu & ~in_done);
      chk("mdu_valid", bus.mdu_valid, in_done);
      if (in_done && exp_q.size() > 0) chk("mdu_result", bus.mdu_result, exp_q.pop_front());
      if (!mdl_busy) chk("state_idle", state_dbg, 2'd0);
      if (rst || bus.kill) begin
        if (mdl_busy && !in_done) void'(exp_q.pop_back());
        mdl_busy = 1'b0;
      end else if (in_done) begin
        mdl_busy = 1'b0;
      end else if (!mdl_busy && exp_mdu) begin
        mdl_busy  = 1'b1;
        mdl_start = cyc;
        exp_q.push_back(m_model(bus.funct3, bus.op_a, bus.op_b));
      end
    end
  end

  // driver tasks (called at posedge+#1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic dec_lit(input logic [1:0] op, input logic [2:0] f3, input logic f5,
                         input logic [3:0] exp, input string name);
    bus.in_valid = 1'b1; bus.ctrl_alu_op = op; bus.funct3 = f3;
    bus.funct7_5 = f5; bus.funct7_0 = 1'b0;
    @(negedge clk);
    chk(name, bus.alu_ctrl, exp);
    step();
  endtask

  task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    int stalls = 0;
    int k = 0;
    bit got = 1'b0;
    logic [31:0] res = '0;
    bus.in_valid = 1'b1; bus.ctrl_alu_op = 2'b10; bus.funct7_0 = 1'b1;
    bus.funct7_5 = 1'b0; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    while (!got && k < 40) begin
      @(negedge clk);
      if (bus.stall) stalls++;
      if (bus.mdu_valid) begin got = 1'b1; res = bus.mdu_result; v_cyc = cyc; end
      step();
      if (k == 0) begin
        bus.op_a = $urandom; bus.op_b = $urandom; bus.funct3 = 3'($urandom_range(0, 7));
      end
      k++;
    end
    chk({name, "_done"}, got, 1'b1);
    chk({name, "_result"}, res, exp);
    chk({name, "_stalls"}, stalls, 33);
    chk({name, "_latency"}, k, 34);
  endtask

  task automatic abort_div(input bit use_rst, input string name);
    int pulses = 0;
    bus.in_valid = 1'b1; bus.ctrl_alu_op = 2'b10; bus.funct7_0 = 1'b1;
    bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd7;
    repeat (11) step();
    bus.in_valid = 1'b0;
    if (use_rst) rst = 1'b1; else bus.kill = 1'b1;
    step();
    rst = 1'b0; bus.kill = 1'b0;
    @(negedge clk);
    chk({name, "_state"}, state_dbg, 2'd0);
    if (use_rst) chk({name, "_result_cleared"}, bus.mdu_result, 32'd0);
    repeat (40) begin
      @(negedge clk);
      if (bus.mdu_valid) pulses++;
    end
    chk({name, "_no_valid"}, pulses, 0);
    step();
  endtask

  // stimulus
  initial begin
    int vc1;
    bus.in_valid = 1'b0; bus.kill = 1'b0; bus.ctrl_alu_op = 2'b00; bus.funct3 = 3'd0;
    bus.funct7_5 = 1'b0; bus.funct7_0 = 1'b0; bus.op_a = '0; bus.op_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mdu_valid", bus.mdu_valid, 1'b0);
    chk("rst_mdu_result", bus.mdu_result, 32'd0);
    chk("rst_state", state_dbg, 2'd0);
    chk("rst_stall", bus.stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int f5 = 0; f5 < 2; f5++) begin
          bus.in_valid = 1'b1; bus.ctrl_alu_op = 2'(op); bus.funct3 = 3'(f3);
          bus.funct7_5 = 1'(f5);
          bus.funct7_0 = (op == 2) ? 1'b0 : 1'($urandom_range(0, 1));
          step();
        end
    dec_lit(2'b10, 3'b000, 1'b1, 4'b1000, "dec_r_sub");
    dec_lit(2'b11, 3'b000, 1'b1, 4'b0000, "dec_addi_imm10");
    dec_lit(2'b11, 3'b101, 1'b1, 4'b1101, "dec_srai");
    dec_lit(2'b00, 3'b111, 1'b1, 4'b0000, "dec_mem");
    dec_lit(2'b01, 3'b010, 1'b0, 4'b1000, "dec_branch");
    idle(1);

    run_mop(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");          idle(1);
    run_mop(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");  idle(1);
    run_mop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"); idle(1);
    run_mop(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu_m1_2");       idle(1);
    run_mop(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");          idle(1);
    run_mop(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");          idle(1);
    run_mop(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7");                     idle(1);
    run_mop(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7");                      idle(1);
    run_mop(3'd4, 32'd9, 32'd0, 32'hFFFF_FFFF, "div_by_zero");               idle(1);
    run_mop(3'd6, 32'd5, 32'd0, 32'd5, "rem_by_zero");                       idle(1);
    run_mop(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_neg_by_zero");   idle(1);
    run_mop(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");            idle(1);
    run_mop(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");   idle(1);
    run_mop(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");           idle(1);

    abort_div(1'b0, "kill_abort");
    run_mop(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_kill");                   idle(1);
    abort_div(1'b1, "rst_abort");
    run_mop(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_rst");

    run_mop(3'd0, 32'd2, 32'd3, 32'd6, "b2b_first");
    vc1 = v_cyc;
    run_mop(3'd0, 32'd4, 32'd5, 32'd20, "b2b_second");
    chk("b2b_spacing", v_cyc - vc1, 34);
    bus.ctrl_alu_op = 2'b10; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.funct7_0 = 1'b0;
    bus.op_a = 32'd1; bus.op_b = 32'd2;
    repeat (4) begin
      @(negedge clk);
      chk("add_no_stall", bus.stall, 1'b0);
      step();
    end
    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
